// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues single-byte reads to instruction memory,
// buffers returned bytes with their addresses in a 2-entry FIFO for decode,
// and handles redirects by flushing buffered and in-flight fetches.
module fetch_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] pc_cur,
    output logic [7:0] pc_next,
    output logic       pc_en,
    output logic       mem_req,
    output logic [7:0] mem_addr,
    input  logic       mem_ack,
    input  logic [7:0] mem_rdata,
    output logic       instr_valid,
    output logic [7:0] instr_data,
    output logic [7:0] instr_pc,
    input  logic       instr_ready,
    input  logic       redirect,
    input  logic [7:0] redirect_pc,
    input  logic       halt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,   // no request outstanding
        BUSY  = 2'd1,   // request outstanding, data will be kept
        FLUSH = 2'd2    // request outstanding, data will be discarded
    } state_t;

    state_t     state;
    state_t     state_nxt;

    logic [1:0] count;
    logic       rd_ptr;
    logic       wr_ptr;
    logic [7:0] fifo_pc   [2];
    logic [7:0] fifo_data [2];

    logic       pop;
    logic       push;
    logic       issue;
    logic [1:0] count_after_pop;

    // Decode handshake and the occupancy seen by the issue decision.
    assign instr_valid     = (count != 2'd0);
    assign instr_pc        = fifo_pc[rd_ptr];
    assign instr_data      = fifo_data[rd_ptr];
    assign pop             = instr_valid & instr_ready;
    assign count_after_pop = count - {1'b0, pop};

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of block ordering.
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: an issued request always runs to its ack; a redirect
    // while waiting only changes whether the returning byte is kept.
    always_comb begin
        // NOTE: a default assignment first keeps this block free of latches
        // on paths that do not mention state_nxt.
        state_nxt = state;
        case (state)
            IDLE:    if (issue)       state_nxt = BUSY;
            BUSY:    if (mem_ack)     state_nxt = IDLE;
                     else if (redirect) state_nxt = FLUSH;
            FLUSH:   if (mem_ack)     state_nxt = IDLE;
            default:                  state_nxt = IDLE;
        endcase
    end

    // Output decode: issue/push qualifiers and the PC update; redirect wins
    // over the sequential increment and suppresses any issue.
    always_comb begin
        issue   = (state == IDLE) & ~halt & ~redirect & ~reset
                  & (count_after_pop < 2'd2);
        push    = (state == BUSY) & mem_ack & ~redirect & ~reset;
        pc_en   = ~reset & (issue | redirect);
        pc_next = redirect ? redirect_pc : pc_cur + 8'd1;
    end

    // Memory request register: raised on issue, held with a stable address
    // until the ack arrives; acks seen in IDLE are ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_req  <= 1'b0;
            mem_addr <= 8'h00;
        end else if (issue) begin
            mem_req  <= 1'b1;
            mem_addr <= pc_cur;
        end else if (mem_ack && (state != IDLE)) begin
            mem_req  <= 1'b0;
        end
    end

    // FIFO occupancy and pointers; a redirect empties the buffer outright.
    always_ff @(posedge clk) begin
        if (reset || redirect) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    // FIFO storage: written at the tail on every kept ack.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is not reset; count gates every read, so
        // stale contents are never visible to decode.
        if (push) begin
            fifo_pc[wr_ptr]   <= mem_addr;
            fifo_data[wr_ptr] <= mem_rdata;
        end
    end

endmodule
